key_press_classifier: RTL and testbench

Downstream consumer of the edge detector's one-cycle `rising_edge`/`falling_edge` pulses. It times press and release intervals with a counter and classifies each user gesture as a short press, long press or double press. Each classification is reported as a registered one-cycle pulse. It sits between the edge detector and the control FSM that acts on button gestures.

---
 rtl/key_press_classifier.sv | 132 +++++++++++++
 tb/tb_key_press_classifier.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_press_classifier.sv
// key_press_classifier: times press/release intervals driven by edge-detector
// pulses and classifies each gesture as a short, long or double press.
// Every classification is a registered one-cycle pulse and bumps event_count.
module key_press_classifier #(
    parameter int CNT_W       = 16,
    parameter int LONG_CYCLES = 1000,
    parameter int DOUBLE_GAP  = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rise_in,
    input  logic       fall_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] event_count
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HELD        = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_SECOND = 3'd3,
        HELD2       = 3'd4
    } state_t;

    // Terminal counts: the timeout fires on the edge that samples these.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             short_nxt, long_nxt, double_nxt;
    logic             any_nxt;
    logic             rise_ok, fall_ok;

    // Simultaneous rise and fall is a protocol violation: treat as no edge,
    // so timers keep running and no transition is caused by the pair.
    assign rise_ok = rise_in & ~fall_in;
    assign fall_ok = fall_in & ~rise_in;

    // State, interval counter, pulse outputs and event counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            event_count  <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_press <= double_nxt;
            if (any_nxt)
                event_count <= event_count + 8'd1;
        end
    end

    // Next-state and counter logic; pulse decisions are made here so they
    // register on the same edge as the transition that produces them.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_ok) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                // A release on the terminal cycle still counts as a release.
                if (fall_ok) begin
                    state_nxt = WAIT_SECOND;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall_ok)
                    state_nxt = IDLE;
            end
            WAIT_SECOND: begin
                // A second press on the terminal cycle still makes a double.
                if (rise_ok) begin
                    state_nxt = HELD2;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD2: begin
                // A held second press reports the double at the long boundary
                // and then waits silently for the release.
                if (fall_ok) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt  = LONG_HELD;
                    double_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: busy follows the registered state, any_nxt feeds the counter.
    always_comb begin
        busy    = (state != IDLE);
        any_nxt = short_nxt | long_nxt | double_nxt;
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench for key_press_classifier (LONG_CYCLES=10, DOUBLE_GAP=5).
// The stimulus side runs a timestamp-based gesture model and queues the
// expected per-cycle busy value and expected pulses; a monitor compares.
module tb_key_press_classifier;

    localparam int LC = 10;
    localparam int DG = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rise_in, fall_in;
    logic       short_press, long_press, double_press, busy;
    logic [7:0] event_count;

    key_press_classifier #(.CNT_W(16), .LONG_CYCLES(LC), .DOUBLE_GAP(DG)) dut (
        .clk(clk), .reset_n(reset_n), .rise_in(rise_in), .fall_in(fall_in),
        .short_press(short_press), .long_press(long_press),
        .double_press(double_press), .busy(busy), .event_count(event_count)
    );

    always #5 clk = ~clk;

    typedef struct { int ed; bit bsy; } cyc_t;
    typedef struct { int ed; int kind; int cnt; } ev_t;   // kind 1=short 2=long 3=double

    cyc_t cq[$];
    ev_t  eq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Model state: gesture phase plus the edge at which that phase began.
    // 0 idle, 1 first press, 2 long hold, 3 release gap, 4 second press
    int   mode  = 0;
    int   t0    = 0;
    int   sn    = 0;
    int   evcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, sn);
        end
    endtask

    // One clock of stimulus; the model decides what the upcoming edge produces.
    task automatic step(input bit r, input bit f);
        bit   rv, fv;
        int   ek;
        cyc_t c;
        ev_t  e;
        @(negedge clk);
        rise_in = r;
        fall_in = f;
        sn++;
        rv = r && !f;
        fv = f && !r;
        ek = 0;
        case (mode)
            0: if (rv) begin mode = 1; t0 = sn; end
            1: if (fv) begin mode = 3; t0 = sn; end
               else if (sn - t0 == LC) begin mode = 2; ek = 2; end
            2: if (fv) mode = 0;
            3: if (rv) begin mode = 4; t0 = sn; end
               else if (sn - t0 == DG) begin mode = 0; ek = 1; end
            4: if (fv) begin mode = 0; ek = 3; end
               else if (sn - t0 == LC) begin mode = 2; ek = 3; end
            default: mode = 0;
        endcase
        if (ek != 0) begin
            evcnt = (evcnt + 1) % 256;
            e.ed = sn; e.kind = ek; e.cnt = evcnt;
            eq.push_back(e);
        end
        c.ed = sn; c.bsy = (mode != 0);
        cq.push_back(c);
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges while a gesture is in progress.
    task automatic async_reset();
        @(posedge clk);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pulses", short_press | long_press | double_press, 0);
        chk("rst_event_count", event_count, 0);
        cq.delete();
        eq.delete();
        mode  = 0;
        evcnt = 0;
        rise_in = 1'b0;
        fall_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one busy record per edge, and a pulse record whenever a pulse shows.
    always begin
        int   ka, nh;
        cyc_t c;
        ev_t  e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (cq.size() == 0) begin
                chk("cycle_record_present", 0, 1);
            end else begin
                c  = cq.pop_front();
                chk("busy", busy, c.bsy);
                nh = short_press + long_press + double_press;
                ka = short_press ? 1 : long_press ? 2 : double_press ? 3 : 0;
                if (nh > 1) chk("pulse_onehot", nh, 1);
                if (ka != 0) begin
                    if (eq.size() == 0 || eq[0].ed != c.ed) begin
                        chk("unexpected_pulse", ka, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("pulse_kind", ka, e.kind);
                        chk("event_count", event_count, e.cnt);
                    end
                end else if (eq.size() != 0 && eq[0].ed <= c.ed) begin
                    e = eq.pop_front();
                    chk("missed_pulse", 0, e.kind);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        rise_in = 1'b0;
        fall_in = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_pulses", short_press | long_press | double_press, 0);
        chk("reset_event_count", event_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Short press
        step(1, 0); idle(2); step(0, 1); idle(8);
        // Long press, release much later
        step(1, 0); idle(29); step(0, 1); idle(3);
        // Double press with second rise exactly on the gap boundary
        step(1, 0); idle(1); step(0, 1); idle(4); step(1, 0); idle(1); step(0, 1); idle(3);
        // Second rise one edge too late: short, then a new gesture
        step(1, 0); idle(1); step(0, 1); idle(5); step(1, 0); idle(1); step(0, 1); idle(8);
        // Hold boundary: release one before and exactly at the long boundary
        step(1, 0); idle(8); step(0, 1); idle(8);
        step(1, 0); idle(9); step(0, 1); idle(8);
        // Second press held to the long boundary, then a silent release
        step(1, 0); step(0, 1); idle(1); step(1, 0); idle(14); step(0, 1); idle(3);
        // Simultaneous rise/fall in idle and while held
        step(1, 1); idle(3);
        step(1, 0); step(1, 1); idle(2); step(0, 1); idle(8);
        // Reset mid-press, then quiet cycles with no pulse
        step(1, 0); idle(3);
        async_reset();
        idle(4);
        step(1, 0); step(0, 1); idle(7);
        // event_count wrap across 256 short presses
        for (int i = 0; i < 256; i++) begin
            step(1, 0); idle(1); step(0, 1); idle(6);
        end
        // Randomized edges
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) idle($urandom_range(0, 12));
        end
        step(0, 1);
        idle(20);
        @(posedge clk);
        #2;
        chk("pulse_queue_drained", eq.size(), 0);
        chk("event_count_final", event_count, evcnt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
